// File: rtl/tpi_bus_master_if.sv
// Signal bundle between the TPI bus master, its controller and the
// 6525-style responder pins. The master modport is the initiator's view;
// the slave modport is the view of everything around it.
interface tpi_bus_master_if;
  // controller request / response
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_rs;
  logic       req_write;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  // interrupt vector delivery
  logic       irq_valid;
  logic [4:0] irq_vector;
  logic       irq_ack;
  // responder pins (data pad split into o/oe/i)
  logic       bus_cs_n;
  logic [2:0] bus_rs;
  logic       bus_write_n;
  logic [7:0] bus_data_o;
  logic       bus_data_oe;
  logic [7:0] bus_data_i;
  logic       bus_irq_n;

  modport master (
    input  req_valid, req_rs, req_write, req_wdata, irq_ack,
    input  bus_data_i, bus_irq_n,
    output req_ready, rsp_valid, rsp_rdata, irq_valid, irq_vector,
    output bus_cs_n, bus_rs, bus_write_n, bus_data_o, bus_data_oe
  );

  modport slave (
    output req_valid, req_rs, req_write, req_wdata, irq_ack,
    output bus_data_i, bus_irq_n,
    input  req_ready, rsp_valid, rsp_rdata, irq_valid, irq_vector,
    input  bus_cs_n, bus_rs, bus_write_n, bus_data_o, bus_data_oe
  );
endinterface

// File: rtl/tpi_bus_master.sv
// Host-side initiator for the 6525-style TPI register bus.
// Turns single-register requests into SETUP/STROBE/HOLD/TURN bus cycles and,
// when enabled, reads the Active Interrupt Register (rs=7) on a falling IRQ,
// presenting AIR[4:0] as an interrupt vector. All outputs are registered.
module tpi_bus_master #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int TURN_CYCLES   = 1,
  parameter bit AUTO_IRQ      = 1'b1
) (
  input logic               clock,
  input logic               _reset,
  tpi_bus_master_if.master  tpi
);

  // Phase length clamped to 1..16 and expressed as a down-counter load value.
  function automatic logic [3:0] phase_load(input int cycles);
    int len;
    len = (cycles < 1) ? 1 : ((cycles > 16) ? 16 : cycles);
    return 4'(len - 1);
  endfunction

  localparam logic [3:0] SETUP_LOAD  = phase_load(SETUP_CYCLES);
  localparam logic [3:0] STROBE_LOAD = phase_load(STROBE_CYCLES);
  localparam logic [3:0] HOLD_LOAD   = phase_load(HOLD_CYCLES);
  localparam logic [3:0] TURN_LOAD   = phase_load(TURN_CYCLES);
  localparam int         SYNC_STAGES = 2;
  localparam logic [2:0] AIR_RS      = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    TURN
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             auto_reg, auto_next;      // current transaction is an AIR auto-read
  logic             wr_reg, wr_next;          // current transaction is a write
  logic [7:0]       sample_reg, sample_next;  // byte captured at the end of STROBE
  logic [SYNC_STAGES-1:0] sync_reg;
  logic             armed_reg, armed_next;

  logic             cs_n_reg, cs_n_next;
  logic [2:0]       rs_reg, rs_next;
  logic             write_n_reg, write_n_next;
  logic [7:0]       data_o_reg, data_o_next;
  logic             oe_reg, oe_next;
  logic             req_ready_reg, req_ready_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [7:0]       rsp_rdata_reg, rsp_rdata_next;
  logic             irq_valid_reg, irq_valid_next;
  logic [4:0]       irq_vector_reg, irq_vector_next;

  logic             irq_s;
  logic             irq_s_next;
  logic             trigger;
  logic             trigger_next;
  logic             start_auto;

  assign irq_s      = sync_reg[SYNC_STAGES-1];
  assign irq_s_next = sync_reg[SYNC_STAGES-2];

  // An AIR read is due when IRQ has been seen high since the last one, is now
  // low, and the previous vector has been consumed.
  assign trigger = AUTO_IRQ & armed_reg & ~irq_s & ~irq_valid_reg;

  // Two-flop synchronizer for the asynchronous responder IRQ (idle high).
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], tpi.bus_irq_n};
    end
  end

  // State, phase counter, transaction latch and all registered outputs.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      auto_reg       <= 1'b0;
      wr_reg         <= 1'b0;
      sample_reg     <= 8'd0;
      armed_reg      <= 1'b0;
      cs_n_reg       <= 1'b1;
      rs_reg         <= 3'd0;
      write_n_reg    <= 1'b1;
      data_o_reg     <= 8'd0;
      oe_reg         <= 1'b0;
      req_ready_reg  <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_rdata_reg  <= 8'd0;
      irq_valid_reg  <= 1'b0;
      irq_vector_reg <= 5'd0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      auto_reg       <= auto_next;
      wr_reg         <= wr_next;
      sample_reg     <= sample_next;
      armed_reg      <= armed_next;
      cs_n_reg       <= cs_n_next;
      rs_reg         <= rs_next;
      write_n_reg    <= write_n_next;
      data_o_reg     <= data_o_next;
      oe_reg         <= oe_next;
      req_ready_reg  <= req_ready_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_rdata_reg  <= rsp_rdata_next;
      irq_valid_reg  <= irq_valid_next;
      irq_vector_reg <= irq_vector_next;
    end
  end

  // Next-state and next-output logic for the bus sequencer.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    auto_next       = auto_reg;
    wr_next         = wr_reg;
    sample_next     = sample_reg;
    cs_n_next       = cs_n_reg;
    rs_next         = rs_reg;
    write_n_next    = write_n_reg;
    data_o_next     = data_o_reg;
    oe_next         = oe_reg;
    rsp_valid_next  = 1'b0;
    rsp_rdata_next  = rsp_rdata_reg;
    irq_valid_next  = irq_valid_reg & ~tpi.irq_ack;
    irq_vector_next = irq_vector_reg;
    start_auto      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (trigger) begin
          // Auto-read wins over a pending request, which simply waits.
          start_auto   = 1'b1;
          auto_next    = 1'b1;
          wr_next      = 1'b0;
          rs_next      = AIR_RS;
          write_n_next = 1'b1;
          oe_next      = 1'b0;
          cnt_next     = SETUP_LOAD;
          state_next   = SETUP;
        end else if (tpi.req_valid && req_ready_reg) begin
          auto_next    = 1'b0;
          wr_next      = tpi.req_write;
          rs_next      = tpi.req_rs;
          write_n_next = ~tpi.req_write;
          oe_next      = tpi.req_write;
          if (tpi.req_write) begin
            data_o_next = tpi.req_wdata;
          end
          cnt_next     = SETUP_LOAD;
          state_next   = SETUP;
        end
      end

      SETUP: begin
        // rs/write/data settle before _cs falls; the responder latches on that edge.
        if (cnt_reg == 4'd0) begin
          cs_n_next  = 1'b0;
          cnt_next   = STROBE_LOAD;
          state_next = STROBE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      STROBE: begin
        if (cnt_reg == 4'd0) begin
          // Read data is taken on the edge that ends the strobe.
          sample_next = tpi.bus_data_i;
          cs_n_next   = 1'b1;
          cnt_next    = HOLD_LOAD;
          state_next  = HOLD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      HOLD: begin
        if (cnt_reg == 4'd0) begin
          write_n_next = 1'b1;
          oe_next      = 1'b0;
          cnt_next     = TURN_LOAD;
          state_next   = TURN;
          if (auto_reg) begin
            // A zero vector is a spurious interrupt and is not reported.
            irq_vector_next = sample_reg[4:0];
            irq_valid_next  = (sample_reg[4:0] != 5'd0);
          end else begin
            rsp_valid_next = 1'b1;
            if (!wr_reg) begin
              rsp_rdata_next = sample_reg;
            end
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      TURN: begin
        if (cnt_reg == 4'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Re-arm only after IRQ is seen high, so the stale synchronized low left
    // over from one interrupt cannot pop the responder's AIR stack twice.
    if (irq_s) begin
      armed_next = 1'b1;
    end else if (start_auto) begin
      armed_next = 1'b0;
    end else begin
      armed_next = armed_reg;
    end

    // req_ready is registered, so it is derived from the next-cycle view of
    // the same condition that IDLE will evaluate.
    trigger_next   = AUTO_IRQ & armed_next & ~irq_s_next & ~irq_valid_next;
    req_ready_next = (state_next == IDLE) & ~trigger_next;
  end

  assign tpi.req_ready   = req_ready_reg;
  assign tpi.rsp_valid   = rsp_valid_reg;
  assign tpi.rsp_rdata   = rsp_rdata_reg;
  assign tpi.irq_valid   = irq_valid_reg;
  assign tpi.irq_vector  = irq_vector_reg;
  assign tpi.bus_cs_n    = cs_n_reg;
  assign tpi.bus_rs      = rs_reg;
  assign tpi.bus_write_n = write_n_reg;
  assign tpi.bus_data_o  = data_o_reg;
  assign tpi.bus_data_oe = oe_reg;

endmodule

// File: doc/tpi_bus_master.md
Name: tpi_bus_master

Overview:
- Host-side initiator for the 6525-style TPI register bus. Converts single-register read/write requests from a CPU/controller into correctly sequenced _cs/rs/_write/data bus cycles toward a 6525-compatible responder.
- Monitors the responder's IRQ output. When enabled, it automatically reads the Active Interrupt Register (rs=7) and presents the interrupt vector to the controller.
- Sits between the controller and the Fake6525 pins. Tristate data is split into o/oe/i; the top level owns the pad.

Parameters:
- SETUP_CYCLES, 1, cycles with rs/_write/data driven and bus_cs_n high before the strobe (0 treated as 1).
- STROBE_CYCLES, 2, cycles bus_cs_n is held low (0 treated as 1).
- HOLD_CYCLES, 1, cycles bus_cs_n is high again with rs/_write/data still held (0 treated as 1).
- TURN_CYCLES, 1, idle bus cycles after HOLD before the next access (0 treated as 1).
- AUTO_IRQ, 1, 1 = automatic AIR read on IRQ; 0 = IRQ ignored.

Ports:
- clock  in  1  system clock
- _reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  master can accept a request
- req_rs  in  3  target register select
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse for a host request
- rsp_rdata  out  8  read data; holds its last value after writes
- irq_valid  out  1  interrupt vector pending
- irq_vector  out  5  AIR[4:0] captured by the auto-read
- irq_ack  in  1  consumes irq_valid
- bus_cs_n  out  1  chip select to responder
- bus_rs  out  3  register select
- bus_write_n  out  1  0 = write cycle
- bus_data_o  out  8  data driven to responder
- bus_data_oe  out  1  data output enable
- bus_data_i  in  8  data from responder
- bus_irq_n  in  1  responder IRQ, asynchronous

Behaviour:
- Reset (async, _reset low): state IDLE; bus_cs_n=1, bus_write_n=1, bus_rs=0, bus_data_o=0, bus_data_oe=0, req_ready=0, rsp_valid=0, rsp_rdata=0, irq_valid=0, irq_vector=0, IRQ synchronizer=1, irq_armed=0.
  - Reset mid-access aborts immediately to these values; no rsp_valid is issued.
- All outputs are registered.
- bus_irq_n passes through a 2-flop synchronizer (irq_s).
  - irq_armed is set whenever irq_s=1 and cleared when an auto-read starts.
  - Auto-read trigger: AUTO_IRQ & irq_armed & irq_s=0 & !irq_valid.
- States: IDLE, SETUP, STROBE, HOLD, TURN. One shared 4-bit down-counter loads each phase length.
- IDLE:
  - req_ready=1 unless the auto-read trigger is true.
  - The trigger has priority over a simultaneous req_valid; the request stays pending with req_ready=0.
  - Accept on req_valid & req_ready. On accept, or on the trigger, go to SETUP and latch the transaction (source, rs, write, wdata). Auto-read uses rs=7, read.
  - req_ready drops in the accepting cycle.
- SETUP: bus_rs/bus_write_n valid. For writes, bus_data_oe=1 and bus_data_o=wdata. bus_cs_n=1. The responder latches rs and write data on the falling edge of _cs, so all of these must be stable through SETUP.
- STROBE: bus_cs_n=0, other signals unchanged.
  - Reads: bus_data_i is sampled on the clock edge ending the last STROBE cycle.
- HOLD: bus_cs_n=1, rs/write_n/data/oe unchanged.
- TURN:
  - bus_write_n=1 and bus_data_oe=0; bus_rs holds its last value.
  - Host transaction: rsp_valid=1 for the first TURN cycle only. rsp_rdata is updated to the sampled byte for reads and unchanged for writes.
  - Auto-read: no rsp_valid. irq_vector is set to the sampled byte [4:0]. irq_valid is set if that vector ≠ 0; a zero vector (spurious) is dropped silently.
- After TURN, return to IDLE.
- Latency with defaults: accept edge to rsp_valid is 4 cycles; accept edge to next req_ready is 5 cycles.
- irq_valid stays high until irq_ack=1, then clears on the next edge. irq_ack while irq_valid=0 is ignored. While irq_valid=1, no further auto-reads occur.
- Re-arm rule: after an auto-read, the next auto-read requires irq_s to have been seen high first. This stops the stale synchronized low from triggering a double AIR read, which would pop the responder's stack twice.
- req_valid may drop before acceptance without effect. req_* are not sampled outside the accept cycle.

Test Plan:
- Write rs=3, data 0x5A, defaults -> bus_cs_n low for exactly 2 cycles. bus_rs=3, bus_write_n=0, bus_data_oe=1, bus_data_o=0x5A stable from 1 cycle before cs falls to 1 cycle after cs rises. rsp_valid pulses at accept+4; req_ready returns at accept+5.
- Read rs=1, responder drives 0xC3 -> bus_data_oe=0 throughout. rsp_rdata=0xC3 with rsp_valid one cycle. Then a write of 0x11 leaves rsp_rdata=0xC3.
- bus_irq_n driven low, responder AIR=0x04 -> exactly one rs=7 read. irq_valid=1, irq_vector=0x04 until irq_ack. A second IRQ low-pulse while irq_valid=1 gives no bus cycle until ack.
- bus_irq_n low and req_valid (read rs=0) in the same IDLE cycle -> AIR read first, then rs=0 read. Exactly one rsp_valid, belonging to rs=0.
- AIR read returns 0x00 -> irq_valid stays 0. No repeat read until bus_irq_n goes high then low again.
- _reset asserted during STROBE of a write -> bus_cs_n=1, bus_data_oe=0, bus_write_n=1 immediately, no rsp_valid. After release, req_ready=1 one cycle later and a new read completes normally.
